// File: rtl/data_mem_lsu.sv
// Word-organised data memory with a load/store front end. It handles byte, half and word accesses with
// sign or zero extension. An access that crosses a word boundary is either split into two beats or flagged as an error.
module data_mem_lsu #(
    parameter int          DEPTH    = 32,
    parameter logic [31:0] INIT0    = 32'd7,
    parameter logic [31:0] INIT1    = 32'd12,
    parameter bit          SPLIT_EN = 1'b1,
    localparam int         AW       = $clog2(DEPTH) + 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [1:0]    size_i,
    input  logic          unsigned_i,
    input  logic [31:0]   wdata_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [31:0]   rdata_o,
    output logic          err_o
);

    localparam int IW = AW - 2;

    typedef enum logic {
        S_IDLE,
        S_SECOND
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [31:0]   r_mem [DEPTH];
    logic [IW-1:0] r_idx;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_uns;
    logic          r_we;
    logic [3:0]    r_be_hi;
    logic [31:0]   r_wd_hi;
    logic [31:0]   r_lo;
    logic          r_valid;
    logic          r_err;
    logic [31:0]   r_rdata;

    logic [1:0]    w_off;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_idx_hi;
    logic          w_accept;
    logic          w_cross;
    logic          w_err;
    logic          w_split;
    logic [3:0]    w_mask;
    logic [7:0]    w_be;
    logic [63:0]   w_wd;

    // Shift the two-word window {hi, lo} down to the addressed byte, then extend to 32 bits.
    function automatic logic [31:0] f_extract(input logic [63:0] pair, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
        logic [63:0] sh;
        sh = pair >> {off, 3'b000};
        case (size)
            2'b00:   f_extract = {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   f_extract = {{16{~uns & sh[15]}}, sh[15:0]};
            default: f_extract = sh[31:0];
        endcase
    endfunction

    assign w_off    = addr_i[1:0];
    assign w_idx    = addr_i[AW-1:2];
    assign w_idx_hi = r_idx + IW'(1);
    assign w_accept = req_i && (r_state == S_IDLE);
    assign w_cross  = ((size_i == 2'b01) && (w_off == 2'b11)) ||
                      ((size_i == 2'b10) && (w_off != 2'b00));
    assign w_err    = (size_i == 2'b11) || (w_cross && !SPLIT_EN);
    assign w_split  = w_cross && SPLIT_EN && (size_i != 2'b11);

    // Byte enables and data over an 8-lane window: the low nibble belongs to word W, the high nibble to W+1.
    always_comb begin
        case (size_i)
            2'b00:   w_mask = 4'b0001;
            2'b01:   w_mask = 4'b0011;
            default: w_mask = 4'b1111;
        endcase
        w_be = {4'b0000, w_mask} << w_off;
        w_wd = {32'b0, wdata_i} << {w_off, 3'b000};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && !w_err && w_split) w_state_next = S_SECOND;
            S_SECOND: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // NOTE: the memory is inside the reset branch because reset must restore the INIT words and clear the rest.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= (i == 0) ? INIT0 : (i == 1) ? INIT1 : 32'd0;
            r_idx   <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_we    <= 1'b0;
            r_be_hi <= '0;
            r_wd_hi <= '0;
            r_lo    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            if (w_accept) begin
                if (w_err) begin
                    r_valid <= 1'b1;
                    r_err   <= 1'b1;
                end else begin
                    if (we_i) begin
                        for (int b = 0; b < 4; b++)
                            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
                    end
                    if (w_split) begin
                        r_idx   <= w_idx;
                        r_off   <= w_off;
                        r_size  <= size_i;
                        r_uns   <= unsigned_i;
                        r_we    <= we_i;
                        r_be_hi <= w_be[7:4];
                        r_wd_hi <= w_wd[63:32];
                        r_lo    <= r_mem[w_idx];
                    end else begin
                        r_valid <= 1'b1;
                        r_rdata <= we_i ? 32'd0
                                        : f_extract({32'd0, r_mem[w_idx]}, w_off, size_i, unsigned_i);
                    end
                end
            end else if (r_state == S_SECOND) begin
                if (r_we) begin
                    for (int b = 0; b < 4; b++)
                        if (r_be_hi[b]) r_mem[w_idx_hi][8*b +: 8] <= r_wd_hi[8*b +: 8];
                end
                r_valid <= 1'b1;
                r_rdata <= r_we ? 32'd0
                                : f_extract({r_mem[w_idx_hi], r_lo}, r_off, r_size, r_uns);
            end
        end
    end

    assign ready_o = (r_state == S_IDLE);
    assign valid_o = r_valid;
    assign err_o   = r_err;
    assign rdata_o = r_rdata;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu. It runs one split-enabled instance with queued expectations
// and one split-disabled instance with direct checks.
module tb_data_mem_lsu;

    localparam int DEPTH = 32;
    localparam int AW    = 7;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
        string       tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we, uns, ready, valid, err;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic [31:0]   wdata, rdata;
    logic          req_b, we_b, uns_b, ready_b, valid_b, err_b;
    logic [AW-1:0] addr_b;
    logic [1:0]    size_b;
    logic [31:0]   wdata_b, rdata_b;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_lsu #(.DEPTH(DEPTH), .SPLIT_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .size_i(size),
        .unsigned_i(uns), .wdata_i(wdata), .ready_o(ready), .valid_o(valid), .rdata_o(rdata),
        .err_o(err)
    );

    data_mem_lsu #(.DEPTH(DEPTH), .SPLIT_EN(1'b0)) dut_nosplit (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we_b), .addr_i(addr_b), .size_i(size_b),
        .unsigned_i(uns_b), .wdata_i(wdata_b), .ready_o(ready_b), .valid_o(valid_b),
        .rdata_o(rdata_b), .err_o(err_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every completion on the split-enabled instance must match the oldest queued expectation, on its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", valid, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.tag, "_data"}, rdata, mon_e.data);
                    check({mon_e.tag, "_err"}, err, mon_e.err);
                    check({mon_e.tag, "_lat"}, cyc, mon_e.due);
                end
            end else begin
                check("idle_out", {err, rdata}, '0);
            end
        end
    end

    // Called just after a rising edge. With hold set, req stays high through SECOND while the other inputs are scrambled.
    task automatic drive(input string tag, input logic w, input logic [AW-1:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] wd, input logic [31:0] exp_d,
                         input logic exp_e, input int lat, input bit hold);
        int guard = 0;
        req = 1'b1; we = w; addr = a; size = s; uns = u; wdata = wd;
        while (ready !== 1'b1 && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_ready"}, ready, 1'b1);
        sb.push_back('{exp_d, exp_e, cyc + lat, tag});
        @(posedge clk); #1;
        if (hold) begin
            check({tag, "_busy"}, ready, 1'b0);
            we = ~we; addr = ~addr; wdata = ~wdata; uns = ~uns;
            @(posedge clk); #1;
        end
        req = 1'b0;
    endtask

    task automatic drive_b(input string tag, input logic w, input logic [AW-1:0] a, input logic [1:0] s,
                           input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e);
        req_b = 1'b1; we_b = w; addr_b = a; size_b = s; uns_b = 1'b0; wdata_b = wd;
        check({tag, "_ready"}, ready_b, 1'b1);
        @(posedge clk); #1;
        req_b = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, valid_b, 1'b1);
        check({tag, "_err"}, err_b, exp_e);
        check({tag, "_data"}, rdata_b, exp_d);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; size = 2'b10; uns = 1'b0; wdata = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; size_b = 2'b10; uns_b = 1'b0; wdata_b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", ready, 1'b1);
        check("rst_outs", {valid, err, rdata}, '0);
        check("rst_ready_b", ready_b, 1'b1);
        mon_en = 1'b1;

        // Reset contents, back-to-back
        drive("ld_w0", 0, 7'd0, 2'b10, 0, 0, 32'd7, 0, 1, 0);
        drive("ld_w1", 0, 7'd4, 2'b10, 0, 0, 32'd12, 0, 1, 0);
        // Byte store then immediate loads of the same byte
        drive("st_b5", 1, 7'd5, 2'b00, 0, 32'h80, 32'd0, 0, 1, 0);
        drive("ld_b5s", 0, 7'd5, 2'b00, 0, 0, 32'hFFFFFF80, 0, 1, 0);
        drive("ld_b5u", 0, 7'd5, 2'b00, 1, 0, 32'h00000080, 0, 1, 0);
        drive("ld_w1b", 0, 7'd4, 2'b10, 0, 0, 32'h0000800C, 0, 1, 0);
        // Split word store across the top of memory, req held through SECOND
        drive("st_wrap", 1, 7'd126, 2'b10, 0, 32'hAABBCCDD, 32'd0, 0, 2, 1);
        drive("ld_h31", 0, 7'd126, 2'b01, 1, 0, 32'h0000CCDD, 0, 1, 0);
        drive("ld_h31s", 0, 7'd126, 2'b01, 0, 0, 32'hFFFFCCDD, 0, 1, 0);
        drive("ld_h0", 0, 7'd0, 2'b01, 1, 0, 32'h0000AABB, 0, 1, 0);
        drive("ld_wrap", 0, 7'd126, 2'b10, 0, 0, 32'hAABBCCDD, 0, 2, 1);
        // Split half store at offset 3
        drive("st_h11", 1, 7'd11, 2'b01, 0, 32'h00009234, 32'd0, 0, 2, 0);
        drive("ld_w2", 0, 7'd8, 2'b10, 0, 0, 32'h34000000, 0, 1, 0);
        drive("ld_w3", 0, 7'd12, 2'b10, 0, 0, 32'h00000092, 0, 1, 0);
        drive("ld_h11", 0, 7'd11, 2'b01, 0, 0, 32'hFFFF9234, 0, 2, 0);
        // Lane isolation within a word
        drive("st_h16", 1, 7'd16, 2'b01, 0, 32'hFFFFBEEF, 32'd0, 0, 1, 0);
        drive("st_b18", 1, 7'd18, 2'b00, 0, 32'hFFFFFF5A, 32'd0, 0, 1, 0);
        drive("ld_w4", 0, 7'd16, 2'b10, 0, 0, 32'h005ABEEF, 0, 1, 0);
        drive("ld_b17", 0, 7'd17, 2'b00, 0, 0, 32'hFFFFFFBE, 0, 1, 0);
        // Illegal size
        drive("ld_sz3", 0, 7'd0, 2'b11, 0, 0, 32'd0, 1, 1, 0);
        drive("st_sz3", 1, 7'd8, 2'b11, 0, 32'hFFFFFFFF, 32'd0, 1, 1, 0);
        drive("ld_w2b", 0, 7'd8, 2'b10, 0, 0, 32'h34000000, 0, 1, 0);

        // Reset during SECOND of a split store aborts it without a completion
        repeat (3) @(posedge clk);
        #1;
        req = 1'b1; we = 1'b1; addr = 7'd2; size = 2'b10; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("abort_second", ready, 1'b0);
        rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", ready, 1'b1);
        drive("rst_w0", 0, 7'd0, 2'b10, 0, 0, 32'd7, 0, 1, 0);
        drive("rst_w1", 0, 7'd4, 2'b10, 0, 0, 32'd12, 0, 1, 0);
        drive("rst_w31", 0, 7'd124, 2'b10, 0, 0, 32'd0, 0, 1, 0);
        drive("rst_w2", 0, 7'd8, 2'b10, 0, 0, 32'd0, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1;

        // Split-disabled instance: misalignment and illegal size are errors, memory untouched
        drive_b("ns_ld_mis", 0, 7'd1, 2'b10, 0, 32'd0, 1);
        drive_b("ns_st_mis", 1, 7'd1, 2'b10, 32'hFFFFFFFF, 32'd0, 1);
        drive_b("ns_st_h3", 1, 7'd3, 2'b01, 32'hFFFFFFFF, 32'd0, 1);
        drive_b("ns_ld_w0", 0, 7'd0, 2'b10, 0, 32'd7, 0);
        drive_b("ns_ld_w1", 0, 7'd4, 2'b10, 0, 32'd12, 0);
        drive_b("ns_sz3", 0, 7'd0, 2'b11, 0, 32'd0, 1);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
